// File: rtl/fpu_pkg.sv
// Shared types and constants for the fsqrt issue path.
package fpu_pkg;

    typedef enum logic [1:0] {
        StIdle,
        StOrder,
        StWait,
        StWb
    } fsm_state_e;

    localparam logic [31:0] QNAN     = 32'h7FC0_0000;
    localparam logic [31:0] NEG_ZERO = 32'h8000_0000;

    // Negative operands never reach the unit: -0 passes through, anything else is NaN.
    function automatic logic [31:0] bypass_result(input logic [31:0] op);
        return (op == NEG_ZERO) ? NEG_ZERO : QNAN;
    endfunction

endpackage

// File: rtl/fpu_req_fifo.sv
// In-order request FIFO; power-of-two depth so pointers wrap by overflow.
module fpu_req_fifo #(
    parameter int unsigned DEPTH = 4,
    parameter int unsigned WIDTH = 37
) (
    input  logic             clk,
    input  logic             rstn,
    input  logic             push,
    input  logic             pop,
    input  logic [WIDTH-1:0] wdata,
    output logic             full,
    output logic             empty,
    output logic [WIDTH-1:0] head
);

    localparam int unsigned PtrW = $clog2(DEPTH);
    localparam logic [PtrW-1:0] PtrOne = 1;
    localparam logic [PtrW:0]   CntOne = 1;

    logic [WIDTH-1:0] mem_q [DEPTH];
    logic [PtrW-1:0]  wptr_q, wptr_d;
    logic [PtrW-1:0]  rptr_q, rptr_d;
    logic [PtrW:0]    count_q, count_d;
    logic             do_push, do_pop;

    assign full    = count_q[PtrW];
    assign empty   = (count_q == '0);
    assign head    = mem_q[rptr_q];
    assign do_push = push & ~full;
    assign do_pop  = pop & ~empty;

    always_comb begin
        wptr_d  = wptr_q;
        rptr_d  = rptr_q;
        count_d = count_q;
        if (do_push) begin
            wptr_d = wptr_q + PtrOne;
        end
        if (do_pop) begin
            rptr_d = rptr_q + PtrOne;
        end
        if (do_push && !do_pop) begin
            count_d = count_q + CntOne;
        end else if (do_pop && !do_push) begin
            count_d = count_q - CntOne;
        end
    end

    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            wptr_q  <= '0;
            rptr_q  <= '0;
            count_q <= '0;
        end else begin
            wptr_q  <= wptr_d;
            rptr_q  <= rptr_d;
            count_q <= count_d;
        end
    end

    always_ff @(posedge clk) begin
        if (do_push) begin
            mem_q[wptr_q] <= wdata;
        end
    end

endmodule

// File: rtl/fsqrt_issue.sv
// Queues sqrt requests, issues them in order to an fsqrt unit (or bypasses negative
// operands), and presents each result to writeback.
module fsqrt_issue
    import fpu_pkg::*;
#(
    parameter int unsigned QDEPTH = 4,
    parameter int unsigned TAG_W  = 5
) (
    input  logic             clk,
    input  logic             rstn,
    input  logic             req_valid,
    output logic             req_ready,
    input  logic [TAG_W-1:0] req_tag,
    input  logic [31:0]      req_data,
    output logic             unit_order,
    input  logic             unit_accepted,
    input  logic             unit_done,
    output logic [31:0]      unit_rs1,
    input  logic [31:0]      unit_rd,
    output logic             wb_valid,
    input  logic             wb_ready,
    output logic [TAG_W-1:0] wb_tag,
    output logic [31:0]      wb_data,
    output logic             busy
);

    fsm_state_e       state_q, state_d;
    logic [31:0]      rs1_q, rs1_d;
    logic [31:0]      result_q, result_d;
    logic [TAG_W-1:0] tag_q, tag_d;
    logic             ready_q;

    logic             fifo_full, fifo_empty, fifo_pop;
    logic [TAG_W-1:0] head_tag;
    logic [31:0]      head_data;

    fpu_req_fifo #(
        .DEPTH (QDEPTH),
        .WIDTH (TAG_W + 32)
    ) u_fifo (
        .clk   (clk),
        .rstn  (rstn),
        .push  (req_valid & req_ready),
        .pop   (fifo_pop),
        .wdata ({req_tag, req_data}),
        .full  (fifo_full),
        .empty (fifo_empty),
        .head  ({head_tag, head_data})
    );

    // ready_q keeps req_ready low while reset is held and for no longer.
    assign req_ready  = ready_q & ~fifo_full;
    assign fifo_pop   = (state_q == StWb) & wb_ready;
    assign unit_order = (state_q == StOrder);
    assign unit_rs1   = rs1_q;
    assign wb_valid   = (state_q == StWb);
    assign wb_tag     = tag_q;
    assign wb_data    = result_q;
    assign busy       = ~fifo_empty | (state_q != StIdle);

    always_comb begin
        state_d  = state_q;
        rs1_d    = rs1_q;
        result_d = result_q;
        tag_d    = tag_q;
        unique case (state_q)
            StIdle: begin
                if (!fifo_empty) begin
                    tag_d = head_tag;
                    if (head_data[31]) begin
                        result_d = bypass_result(head_data);
                        state_d  = StWb;
                    end else begin
                        rs1_d   = head_data;
                        state_d = StOrder;
                    end
                end
            end
            StOrder: begin
                if (unit_accepted) begin
                    state_d = StWait;
                end
            end
            StWait: begin
                if (unit_done) begin
                    result_d = unit_rd;
                    state_d  = StWb;
                end
            end
            StWb: begin
                if (wb_ready) begin
                    state_d = StIdle;
                end
            end
            default: state_d = StIdle;
        endcase
    end

    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            state_q  <= StIdle;
            rs1_q    <= '0;
            result_q <= '0;
            tag_q    <= '0;
            ready_q  <= 1'b0;
        end else begin
            state_q  <= state_d;
            rs1_q    <= rs1_d;
            result_q <= result_d;
            tag_q    <= tag_d;
            ready_q  <= 1'b1;
        end
    end

endmodule

// File: tb/tb_fsqrt_issue.sv
// Directed bench for fsqrt_issue: table of single requests plus queueing/reset sequences.
module tb_fsqrt_issue;

    localparam int unsigned TAG_W = 5;
    localparam logic [31:0] QNAN  = 32'h7FC0_0000;
    localparam logic [31:0] NZERO = 32'h8000_0000;

    logic             clk = 1'b0;
    logic             rstn;
    logic             req_valid;
    logic             req_ready;
    logic [TAG_W-1:0] req_tag;
    logic [31:0]      req_data;
    logic             unit_order;
    logic             unit_accepted;
    logic             unit_done;
    logic [31:0]      unit_rs1;
    logic [31:0]      unit_rd;
    logic             wb_valid;
    logic             wb_ready;
    logic [TAG_W-1:0] wb_tag;
    logic [31:0]      wb_data;
    logic             busy;

    int errors = 0;
    int checks = 0;

    always #5 clk = ~clk;

    fsqrt_issue #(
        .QDEPTH (4),
        .TAG_W  (TAG_W)
    ) dut (
        .clk           (clk),
        .rstn          (rstn),
        .req_valid     (req_valid),
        .req_ready     (req_ready),
        .req_tag       (req_tag),
        .req_data      (req_data),
        .unit_order    (unit_order),
        .unit_accepted (unit_accepted),
        .unit_done     (unit_done),
        .unit_rs1      (unit_rs1),
        .unit_rd       (unit_rd),
        .wb_valid      (wb_valid),
        .wb_ready      (wb_ready),
        .wb_tag        (wb_tag),
        .wb_data       (wb_data),
        .busy          (busy)
    );

    typedef struct {
        logic [TAG_W-1:0] tag;
        logic [31:0]      data;
        bit               normal;
        logic [31:0]      unit_res;
        logic [31:0]      exp;
    } vec_t;

    vec_t vecs[8];

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h", nm, act, exp);
        end
    endtask

    task automatic chk1(input string nm, input logic act, input logic exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %b expected %b", nm, act, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic check_all_zero(input string nm);
        chk1($sformatf("%s_req_ready", nm), req_ready, 1'b0);
        chk1($sformatf("%s_unit_order", nm), unit_order, 1'b0);
        chk($sformatf("%s_unit_rs1", nm), unit_rs1, 32'h0);
        chk1($sformatf("%s_wb_valid", nm), wb_valid, 1'b0);
        chk($sformatf("%s_wb_tag", nm), 32'(wb_tag), 32'h0);
        chk($sformatf("%s_wb_data", nm), wb_data, 32'h0);
        chk1($sformatf("%s_busy", nm), busy, 1'b0);
    endtask

    // One request into an idle, empty block; unit answers 5 cycles after accept.
    task automatic run_one(input vec_t v, input int idx);
        req_valid = 1'b1;
        req_tag   = v.tag;
        req_data  = v.data;
        step();
        req_valid = 1'b0;
        chk1($sformatf("v%0d_busy", idx), busy, 1'b1);
        step();
        chk1($sformatf("v%0d_order_t2", idx), unit_order, v.normal);
        chk1($sformatf("v%0d_wb_t2", idx), wb_valid, !v.normal);
        if (v.normal) begin
            chk($sformatf("v%0d_rs1", idx), unit_rs1, v.data);
            unit_accepted = 1'b1;
            step();
            unit_accepted = 1'b0;
            chk1($sformatf("v%0d_order_drop", idx), unit_order, 1'b0);
            repeat (4) step();
            chk($sformatf("v%0d_rs1_wait", idx), unit_rs1, v.data);
            chk1($sformatf("v%0d_no_wb_wait", idx), wb_valid, 1'b0);
            unit_done = 1'b1;
            unit_rd   = v.unit_res;
            step();
            unit_done = 1'b0;
            unit_rd   = 32'hDEAD_BEEF;
            chk1($sformatf("v%0d_wb_d1", idx), wb_valid, 1'b1);
        end
        chk($sformatf("v%0d_tag", idx), 32'(wb_tag), 32'(v.tag));
        chk($sformatf("v%0d_data", idx), wb_data, v.exp);
        wb_ready = 1'b1;
        step();
        wb_ready = 1'b0;
        chk1($sformatf("v%0d_wb_gone", idx), wb_valid, 1'b0);
        chk1($sformatf("v%0d_idle", idx), busy, 1'b0);
    endtask

    // Service whatever the head is and check the result it offers.
    task automatic drain_one(input string nm, input logic [TAG_W-1:0] etag,
                             input logic [31:0] edata, input logic [31:0] eres,
                             input bit normal, input logic [31:0] ures);
        int n = 0;
        while (!unit_order && !wb_valid && n < 20) begin
            step();
            n++;
        end
        chk1($sformatf("%s_arrive", nm), n < 20, 1'b1);
        chk1($sformatf("%s_order", nm), unit_order, normal);
        if (unit_order) begin
            chk($sformatf("%s_rs1", nm), unit_rs1, edata);
            unit_accepted = 1'b1;
            step();
            unit_accepted = 1'b0;
            step();
            unit_done = 1'b1;
            unit_rd   = ures;
            step();
            unit_done = 1'b0;
        end
        chk1($sformatf("%s_wb_valid", nm), wb_valid, 1'b1);
        chk($sformatf("%s_tag", nm), 32'(wb_tag), 32'(etag));
        chk($sformatf("%s_data", nm), wb_data, eres);
        wb_ready = 1'b1;
        step();
        wb_ready = 1'b0;
    endtask

    initial begin
        logic [31:0] fill[5];
        int bad;

        vecs[0] = '{5'd3,  32'h4080_0000, 1'b1, 32'h4000_0000, 32'h4000_0000};
        vecs[1] = '{5'd7,  32'hBF80_0000, 1'b0, 32'h0,         QNAN};
        vecs[2] = '{5'd8,  32'h8000_0000, 1'b0, 32'h0,         NZERO};
        vecs[3] = '{5'd9,  32'h4110_0000, 1'b1, 32'h4040_0000, 32'h4040_0000};
        vecs[4] = '{5'd10, 32'hC000_0000, 1'b0, 32'h0,         QNAN};
        vecs[5] = '{5'd11, 32'h0000_0000, 1'b1, 32'h0000_0000, 32'h0000_0000};
        vecs[6] = '{5'd12, 32'hFF80_0000, 1'b0, 32'h0,         QNAN};
        vecs[7] = '{5'd31, 32'h7F80_0000, 1'b1, 32'h7F80_0000, 32'h7F80_0000};

        fill[0] = 32'hC080_0000;
        fill[1] = 32'h4080_0000;
        fill[2] = 32'h8000_0000;
        fill[3] = 32'h4110_0000;
        fill[4] = 32'h3F80_0000;

        rstn          = 1'b0;
        req_valid     = 1'b0;
        req_tag       = '0;
        req_data      = '0;
        unit_accepted = 1'b0;
        unit_done     = 1'b0;
        unit_rd       = '0;
        wb_ready      = 1'b0;

        #12;
        check_all_zero("rst");
        @(negedge clk);
        rstn = 1'b1;
        step();
        chk1("ready_after_release", req_ready, 1'b1);

        for (int i = 0; i < 8; i++) begin
            run_one(vecs[i], i);
        end

        // Back-to-back bypass heads: no order, results in push order.
        req_valid = 1'b1;
        req_tag   = 5'd7;
        req_data  = 32'hBF80_0000;
        step();
        req_tag  = 5'd8;
        req_data = 32'h8000_0000;
        step();
        req_valid = 1'b0;
        drain_one("q41a", 5'd7, 32'hBF80_0000, QNAN, 1'b0, 32'h0);
        drain_one("q41b", 5'd8, 32'h8000_0000, NZERO, 1'b0, 32'h0);

        // Normal then bypass: the normal result must come out first.
        req_valid = 1'b1;
        req_tag   = 5'd9;
        req_data  = 32'h4110_0000;
        step();
        req_tag  = 5'd10;
        req_data = 32'hC000_0000;
        step();
        req_valid = 1'b0;
        drain_one("q43a", 5'd9, 32'h4110_0000, 32'h4040_0000, 1'b1, 32'h4040_0000);
        drain_one("q43b", 5'd10, 32'hC000_0000, QNAN, 1'b0, 32'h0);

        // Fill with writeback stalled: 5th request must be refused.
        wb_ready = 1'b0;
        for (int i = 0; i < 4; i++) begin
            req_valid = 1'b1;
            req_tag   = 5'(i + 1);
            req_data  = fill[i];
            chk1($sformatf("fill%0d_ready", i), req_ready, 1'b1);
            step();
        end
        req_tag  = 5'd5;
        req_data = fill[4];
        chk1("full_ready", req_ready, 1'b0);
        bad = 0;
        for (int i = 0; i < 10; i++) begin
            step();
            if (req_ready !== 1'b0 || wb_valid !== 1'b1 || wb_data !== QNAN || wb_tag !== 5'd1)
                bad++;
        end
        chk("full_hold_bad_cycles", 32'(bad), 32'h0);
        req_valid = 1'b0;
        drain_one("q42a", 5'd1, fill[0], QNAN, 1'b0, 32'h0);
        chk1("ready_after_pop", req_ready, 1'b1);
        drain_one("q42b", 5'd2, fill[1], 32'h4000_0000, 1'b1, 32'h4000_0000);
        drain_one("q42c", 5'd3, fill[2], NZERO, 1'b0, 32'h0);
        drain_one("q42d", 5'd4, fill[3], 32'h4040_0000, 1'b1, 32'h4040_0000);
        chk1("q42_empty", busy, 1'b0);

        // Stray accept while idle, then order held with stray done ignored.
        unit_accepted = 1'b1;
        step();
        unit_accepted = 1'b0;
        chk1("stray_acc_order", unit_order, 1'b0);
        chk1("stray_acc_busy", busy, 1'b0);
        req_valid = 1'b1;
        req_tag   = 5'd12;
        req_data  = 32'h4080_0000;
        step();
        req_valid = 1'b0;
        step();
        bad = 0;
        for (int i = 0; i < 6; i++) begin
            if (unit_order !== 1'b1 || unit_rs1 !== 32'h4080_0000 || wb_valid !== 1'b0)
                bad++;
            unit_done = (i == 2);
            unit_rd   = 32'h1234_5678;
            step();
        end
        unit_done = 1'b0;
        chk("order_hold_bad_cycles", 32'(bad), 32'h0);
        drain_one("q44", 5'd12, 32'h4080_0000, 32'h4000_0000, 1'b1, 32'h4000_0000);

        // Reset while waiting on the unit; a late done must be ignored.
        req_valid = 1'b1;
        req_tag   = 5'd20;
        req_data  = 32'h4110_0000;
        step();
        req_valid = 1'b0;
        step();
        unit_accepted = 1'b1;
        step();
        unit_accepted = 1'b0;
        chk1("wait_busy", busy, 1'b1);
        #2;
        rstn = 1'b0;
        #1;
        check_all_zero("midrst");
        repeat (2) step();
        chk1("midrst_ready_held", req_ready, 1'b0);
        @(negedge clk);
        rstn = 1'b1;
        step();
        chk1("ready_after_midrst", req_ready, 1'b1);
        unit_done = 1'b1;
        unit_rd   = 32'h4040_0000;
        step();
        unit_done = 1'b0;
        bad = 0;
        for (int i = 0; i < 5; i++) begin
            if (wb_valid !== 1'b0 || unit_order !== 1'b0 || busy !== 1'b0)
                bad++;
            step();
        end
        chk("late_done_bad_cycles", 32'(bad), 32'h0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/fsqrt_issue.md
FSQRT_ISSUE -- requirements
Module: fsqrt_issue

Interface
REQ-001 Parameter: QDEPTH, 4, request queue depth; power of two, 2 or more.
REQ-002 Parameter: TAG_W, 5, destination-register tag width.
REQ-003 Port: clk  in  1  single clock; all state changes on rising edge.
REQ-004 Port: rstn  in  1  reset, asynchronous and active-low.
REQ-005 Port: req_valid  in  1  core offers a sqrt request.
REQ-006 Port: req_ready  out  1  queue can take a request this cycle.
REQ-007 Port: req_tag  in  TAG_W  destination tag.
REQ-008 Port: req_data  in  32  IEEE-754 single operand.
REQ-009 Port: unit_order  out  1  order to downstream fsqrt unit.
REQ-010 Port: unit_accepted  in  1  fsqrt took the order.
REQ-011 Port: unit_done  in  1  fsqrt result valid this cycle only.
REQ-012 Port: unit_rs1  out  32  operand to fsqrt.
REQ-013 Port: unit_rd  in  32  fsqrt result.
REQ-014 Port: wb_valid  out  1  result offered to writeback.
REQ-015 Port: wb_ready  in  1  writeback takes the result.
REQ-016 Port: wb_tag  out  TAG_W  tag of the offered result.
REQ-017 Port: wb_data  out  32  offered result.
REQ-018 Port: busy  out  1  queue non-empty or FSM not IDLE.

Function
REQ-019 The queue SHALL be an in-order FIFO of {tag, data}; the push condition is req_valid & req_ready.
REQ-020 req_ready SHALL be count < QDEPTH, registered-count based, with no combinational path from wb_ready or unit_*.
REQ-021 A full queue SHALL NOT accept a push in the same cycle as a pop.
REQ-022 The head FSM SHALL have the states IDLE, ORDER, WAIT and WB.
REQ-023 IDLE with the queue non-empty SHALL go to ORDER for a normal head, or to WB for a bypass head.
REQ-024 A bypass head is one of: sign=1 and value not 0x80000000, giving result 0x7FC00000; or exactly 0x80000000, giving result 0x80000000.
REQ-025 unit_order SHALL be 1 exactly while in ORDER; ORDER SHALL go to WAIT on the cycle unit_accepted=1.
REQ-026 unit_rs1 SHALL equal the head data from ORDER entry until leaving WAIT, and SHALL be held stable throughout.
REQ-027 WAIT with unit_done=1 SHALL capture unit_rd into the result register and go to WB.
REQ-028 WB SHALL drive wb_valid=1 with the head tag and the result, and SHALL hold them stable until wb_ready=1.
REQ-029 WB with wb_ready=1 SHALL pop the head and go to IDLE.
REQ-030 unit_done or unit_accepted arriving outside WAIT or ORDER respectively SHALL be ignored.
REQ-031 Latency: a push in cycle t into an empty, IDLE block gives unit_order=1 in cycle t+2, or wb_valid=1 in t+2 for a bypass.
REQ-032 Latency: done in cycle d gives wb_valid in d+1; a pop in cycle p gives the next head's order or wb_valid at p+2.
REQ-033 Results SHALL leave in request order, including when bypass and normal entries are mixed.
REQ-034 Pointers SHALL wrap modulo QDEPTH; count SHALL be width clog2(QDEPTH)+1.

Reset
REQ-035 rstn=0 SHALL asynchronously clear count, pointers, FSM (IDLE) and the result register.
REQ-036 During reset: req_ready=0, unit_order=0, unit_rs1=0, wb_valid=0, wb_tag=0, wb_data=0, busy=0.
REQ-037 After reset release, req_ready SHALL be 1 from the first clock edge; an in-flight operation SHALL be discarded.

Structure
REQ-038 Package fpu_pkg SHALL hold the FSM state type and the constants QNAN=0x7FC00000 and NEG_ZERO=0x80000000.
REQ-039 The FIFO SHALL be the sub-module fpu_req_fifo (parameters DEPTH and WIDTH; push, pop, full, empty, head).

Verification
REQ-040 Push 0x40800000 with tag 3; model returns 0x40000000 5 cycles after accept -> unit_rs1=0x40800000, then wb_valid, wb_tag=3, wb_data=0x40000000.
REQ-041 Push 0xBF800000 (tag 7), then 0x80000000 (tag 8) -> no unit_order; wb 0x7FC00000/7, then 0x80000000/8.
REQ-042 wb_ready=0, push 5 requests -> req_ready=0 once 4 are queued; wb_valid and wb_data stable for 10 cycles; later all 4 are drained in order.
REQ-043 Push 0x41100000 then 0xC0000000 -> 0x40400000 delivered first, then 0x7FC00000; order preserved.
REQ-044 Hold unit_accepted=0 for 6 cycles -> unit_order held at 1 with unit_rs1 stable.
REQ-045 Assert rstn=0 in WAIT, then issue unit_done after release -> all outputs 0 during reset, late done ignored, wb_valid stays 0.
